// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and default parameters for the MEM stage.
package mem_stage_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam logic [31:0] POISON_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/dmem_handshake_fsm.sv
// dmem_handshake_fsm: data-memory request handshake with saturating timeout counter.
module dmem_handshake_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        start,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ready,
  output state_t      state,
  output logic        req,
  output logic        we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic        done,
  output logic        timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  assign done    = state == ACCESS && ready;
  assign timeout = state == ACCESS && !ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      req       <= 1'b0;
      we        <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      cnt       <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state     <= ACCESS;
        req       <= 1'b1;
        we        <= store;
        req_addr  <= addr;
        req_wdata <= wdata;
        cnt       <= '0;
      end
    end else begin
      if (done || timeout) begin
        state <= IDLE;
        req   <= 1'b0;
      end
      cnt <= &cnt ? cnt : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with data-memory handshake, branch resolve and MEM/WB registers.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] POISON_DATA    = POISON_DATA_DEF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        RegWriteEN_In,
  input  logic        Mem2RegSEL_In,
  input  logic        MemWriteEN_In,
  input  logic        Branch_In,
  input  logic        ZeroFlag_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] WriteData_In,
  input  logic [31:0] WriteReg_In,
  input  logic [31:0] PC_In,
  output logic        DMemReq,
  output logic        DMemWE,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic        MemStall,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        MemError,
  output logic        RegWriteEN_Out,
  output logic        Mem2RegSEL_Out,
  output logic [31:0] ReadData_Out,
  output logic [31:0] ALUResult_Out,
  output logic [31:0] WriteReg_Out
);
  state_t state;
  logic   is_mem, done, timeout, complete;
  assign is_mem       = Mem2RegSEL_In | MemWriteEN_In;
  assign complete     = (state == IDLE && !is_mem) || done || timeout;
  assign MemStall     = !complete;
  assign PCSrc        = Branch_In & ZeroFlag_In & ~MemStall;
  assign BranchTarget = PC_In;
  dmem_handshake_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .start     (is_mem),
    .store     (MemWriteEN_In),
    .addr      (ALUResult_In),
    .wdata     (WriteData_In),
    .ready     (DMemReady),
    .state     (state),
    .req       (DMemReq),
    .we        (DMemWE),
    .req_addr  (DMemAddr),
    .req_wdata (DMemWData),
    .done      (done),
    .timeout   (timeout)
  );
  // Stalled cycles insert a bubble; a timed-out access completes without writing back.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      MemError       <= 1'b0;
      RegWriteEN_Out <= 1'b0;
      Mem2RegSEL_Out <= 1'b0;
      ReadData_Out   <= '0;
      ALUResult_Out  <= '0;
      WriteReg_Out   <= '0;
    end else begin
      MemError       <= MemError | timeout;
      RegWriteEN_Out <= complete & ~timeout & RegWriteEN_In;
      Mem2RegSEL_Out <= complete & Mem2RegSEL_In;
      if (complete) begin
        ALUResult_Out <= ALUResult_In;
        WriteReg_Out  <= WriteReg_In;
      end
      ReadData_Out <= timeout ? POISON_DATA : (done && !DMemWE) ? DMemRData : ReadData_Out;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table plus handshake sequences checked against a MEM/WB scoreboard.
module tb_mem_wb_stage;
  localparam int T = 4;
  localparam logic [31:0] POISON = 32'hDEADBEEF;
  logic        CLOCK = 1'b0, RESET = 1'b1;
  logic        RegWriteEN_In = 0, Mem2RegSEL_In = 0, MemWriteEN_In = 0, Branch_In = 0, ZeroFlag_In = 0;
  logic [31:0] ALUResult_In = 0, WriteData_In = 0, WriteReg_In = 0, PC_In = 0;
  logic [31:0] DMemRData = 0;
  logic        DMemReady = 0;
  logic        DMemReq, DMemWE, MemStall, PCSrc, MemError, RegWriteEN_Out, Mem2RegSEL_Out;
  logic [31:0] DMemAddr, DMemWData, BranchTarget, ReadData_Out, ALUResult_Out, WriteReg_Out;
  int n_checks = 0, n_fail = 0;
  logic [31:0] last_rd = 0;
  logic err_exp = 0;

  typedef struct { logic rwe, m2r; logic [31:0] alu, wreg, rdata; } wb_t;
  typedef struct { logic rwe, br, zf; logic [31:0] alu, wreg, pc; logic pcsrc; } vec_t;
  wb_t  sb[$];
  vec_t vecs[4];

  mem_wb_stage #(.TIMEOUT_CYCLES(T), .POISON_DATA(POISON)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In), .MemWriteEN_In(MemWriteEN_In),
    .Branch_In(Branch_In), .ZeroFlag_In(ZeroFlag_In),
    .ALUResult_In(ALUResult_In), .WriteData_In(WriteData_In), .WriteReg_In(WriteReg_In), .PC_In(PC_In),
    .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemRData(DMemRData), .DMemReady(DMemReady),
    .MemStall(MemStall), .PCSrc(PCSrc), .BranchTarget(BranchTarget), .MemError(MemError),
    .RegWriteEN_Out(RegWriteEN_Out), .Mem2RegSEL_Out(Mem2RegSEL_Out),
    .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out), .WriteReg_Out(WriteReg_Out)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rwe, m2r, mwe, br, zf, input logic [31:0] alu, wd, wr, pc);
    RegWriteEN_In = rwe; Mem2RegSEL_In = m2r; MemWriteEN_In = mwe; Branch_In = br; ZeroFlag_In = zf;
    ALUResult_In = alu; WriteData_In = wd; WriteReg_In = wr; PC_In = pc;
  endtask

  task automatic pop_cmp();
    wb_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk("wb_rwe", RegWriteEN_Out, e.rwe);
      chk("wb_m2r", Mem2RegSEL_Out, e.m2r);
      chk("wb_alu", ALUResult_Out, e.alu);
      chk("wb_wreg", WriteReg_Out, e.wreg);
      chk("wb_rdata", ReadData_Out, e.rdata);
    end
  endtask

  task automatic mem_op(input logic store, input logic [31:0] addr, wdata, wreg, rdata, input int ready_at);
    logic fin;
    drive(!store, !store, store, 1'b1, 1'b1, addr, wdata, wreg, 32'h300);
    #1;
    chk("issue_stall", MemStall, 1);
    chk("issue_pcsrc", PCSrc, 0);
    tick();
    chk("issue_bubble", RegWriteEN_Out, 0);
    for (int k = 1; k <= T; k++) begin
      DMemReady = (k == ready_at);
      DMemRData = rdata;
      #1;
      chk("req", DMemReq, 1);
      chk("we", DMemWE, store);
      chk("addr", DMemAddr, addr);
      chk("wdata", DMemWData, wdata);
      fin = DMemReady || k == T;
      chk("stall", MemStall, !fin);
      if (fin) begin
        if (DMemReady) begin
          if (!store) last_rd = rdata;
          sb.push_back('{rwe: !store, m2r: !store, alu: addr, wreg: wreg, rdata: last_rd});
        end else begin
          last_rd = POISON;
          err_exp = 1;
          sb.push_back('{rwe: 1'b0, m2r: !store, alu: addr, wreg: wreg, rdata: POISON});
        end
        tick();
        DMemReady = 0;
        pop_cmp();
        chk("mem_error", MemError, err_exp);
        chk("req_drop", DMemReq, 0);
        break;
      end
      tick();
      chk("wait_bubble", RegWriteEN_Out, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vecs[0] = '{rwe: 1, br: 0, zf: 0, alu: 32'h10, wreg: 32'h5, pc: 32'h0, pcsrc: 0};
    vecs[1] = '{rwe: 1, br: 1, zf: 1, alu: 32'h20, wreg: 32'h6, pc: 32'h200, pcsrc: 1};
    vecs[2] = '{rwe: 0, br: 1, zf: 0, alu: 32'h30, wreg: 32'h7, pc: 32'h204, pcsrc: 0};
    vecs[3] = '{rwe: 1, br: 0, zf: 1, alu: 32'hFFFF_FFFF, wreg: 32'h1F, pc: 32'h208, pcsrc: 0};
    tick();
    tick();
    RESET = 0;
    chk("rst_rwe", RegWriteEN_Out, 0);
    chk("rst_m2r", Mem2RegSEL_Out, 0);
    chk("rst_alu", ALUResult_Out, 0);
    chk("rst_rdata", ReadData_Out, 0);
    chk("rst_wreg", WriteReg_Out, 0);
    chk("rst_req", DMemReq, 0);
    chk("rst_addr", DMemAddr, 0);
    chk("rst_err", MemError, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rwe, 0, 0, vecs[i].br, vecs[i].zf, vecs[i].alu, 0, vecs[i].wreg, vecs[i].pc);
      #1;
      chk("alu_stall", MemStall, 0);
      chk("pcsrc", PCSrc, vecs[i].pcsrc);
      chk("target", BranchTarget, vecs[i].pc);
      sb.push_back('{rwe: vecs[i].rwe, m2r: 1'b0, alu: vecs[i].alu, wreg: vecs[i].wreg, rdata: last_rd});
      tick();
      pop_cmp();
    end
    mem_op(0, 32'h40, 32'h0, 32'h3, 32'hCAFE, 1);
    mem_op(1, 32'h80, 32'h1234, 32'h4, 32'h0, 3);
    mem_op(0, 32'h90, 32'h0, 32'h8, 32'hBEEF_0001, T);
    mem_op(0, 32'hA0, 32'h0, 32'h9, 32'h0BAD_0BAD, 0);
    tick();
    chk("err_sticky", MemError, 1);
    mem_op(0, 32'h44, 32'h0, 32'h2, 32'h1111, 2);
    drive(1, 1, 0, 0, 0, 32'h48, 0, 32'hA, 0);
    tick();
    tick();
    RESET = 1;
    tick();
    RESET = 0;
    DMemReady = 1;
    DMemRData = 32'h5555;
    #1;
    chk("mid_rst_req", DMemReq, 0);
    chk("mid_rst_err", MemError, 0);
    chk("mid_rst_rwe", RegWriteEN_Out, 0);
    chk("mid_rst_rdata", ReadData_Out, 0);
    chk("mid_rst_alu", ALUResult_Out, 0);
    tick();
    chk("late_ready_rdata", ReadData_Out, 0);
    chk("late_ready_rwe", RegWriteEN_Out, 0);
    chk("late_ready_alu", ALUResult_Out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM stage of the five-stage pipeline, consuming the EX/MEM pipeline register outputs. Drives a data-memory port with a valid/ready handshake and stalls the upstream pipeline while an access is outstanding. Resolves the taken-branch select and registers the MEM/WB outputs consumed by write-back. A timeout counter turns a hung memory port into a flagged, completed instruction instead of a deadlock.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles waiting for DMemReady before abort (≥1).
- POISON_DATA, 32'hDEADBEEF: ReadData_Out value on a timed-out load.

Ports:
- CLOCK  in  1  sole clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In, ZeroFlag_In  in  1 each  EX/MEM control.
- ALUResult_In, WriteData_In, WriteReg_In, PC_In  in  32 each  EX/MEM data; PC_In is the branch target.
- DMemReq  out  1  request valid; held until accepted.
- DMemWE  out  1  1 = store, 0 = load.
- DMemAddr, DMemWData  out  32 each  captured address / store data.
- DMemRData  in  32  load data, valid when DMemReady=1.
- DMemReady  in  1  access complete this cycle.
- MemStall  out  1  upstream must hold EX/MEM and earlier stages.
- PCSrc  out  1  taken branch, combinational.
- BranchTarget  out  32  = PC_In.
- MemError  out  1  sticky timeout flag.
- RegWriteEN_Out, Mem2RegSEL_Out  out  1 each  MEM/WB control.
- ReadData_Out, ALUResult_Out, WriteReg_Out  out  32 each  MEM/WB data.

## Operation
- isMem = Mem2RegSEL_In | MemWriteEN_In; a store is MemWriteEN_In=1 (takes precedence if both are set).
- States: IDLE, ACCESS.
- IDLE, isMem=0:
  - MemStall=0.
  - MEM/WB latches the inputs next edge; ReadData_Out holds its prior value.
- IDLE, isMem=1:
  - MemStall=1; MEM/WB takes a bubble (RegWriteEN_Out=0, Mem2RegSEL_Out=0).
  - Capture DMemAddr=ALUResult_In, DMemWData=WriteData_In, DMemWE; clear the counter; go to ACCESS.
- ACCESS:
  - DMemReq=1 with address, data and DMemWE stable; counter increments each cycle.
  - DMemReady=1: MemStall=0 that cycle; MEM/WB latches the instruction, with ReadData_Out=DMemRData for loads; go to IDLE.
  - Otherwise MemStall=1 and MEM/WB takes a bubble.
- Timeout (counter reaches TIMEOUT_CYCLES-1 with DMemReady=0):
  - MemStall=0 that cycle; instruction completes with RegWriteEN_Out=0 and ReadData_Out=POISON_DATA.
  - MemError set; go to IDLE.
- DMemReady on the timeout cycle: the ready completion wins; no error.
- PCSrc = Branch_In & ZeroFlag_In & ~MemStall.
- Counter width is clog2(TIMEOUT_CYCLES)+1 and saturates, never wraps.

## Timing
- Non-memory instruction: 1-cycle latency to MEM/WB.
- Memory instruction: ≥2 cycles (IDLE issue cycle + ACCESS cycle(s)); minimum when DMemReady arrives on the first ACCESS cycle.
- DMemReq first asserts the cycle after the op is seen in IDLE; DMemReq never deasserts in ACCESS before DMemReady or timeout.
- Reset values: all outputs 0, state IDLE, counter 0, MemError 0.
- RESET mid-ACCESS: next cycle state=IDLE and DMemReq=0; a late DMemReady is ignored.
- MemError clears only on RESET.

## Structure
- Shared package mem_stage_pkg:
  - state enum {IDLE, ACCESS};
  - default TIMEOUT_CYCLES and POISON_DATA constants.
- One sub-module, dmem_handshake_fsm: state, counter, captured address/data, DMemReq, and a done/timeout pulse.
- The top level holds the MEM/WB registers, PCSrc and MemError.

## Test plan
- ALU op, RegWriteEN_In=1, ALUResult_In=32'h10 -> next cycle ALUResult_Out=32'h10, RegWriteEN_Out=1, MemStall never high.
- Load from addr 32'h40, DMemReady on the 1st ACCESS cycle with DMemRData=32'hCAFE -> MemStall high for exactly 1 cycle; ReadData_Out=32'hCAFE 2 cycles after issue.
- Store of 32'h1234 to 32'h80, DMemReady after 3 ACCESS cycles -> DMemReq/DMemWE=1, DMemWData=32'h1234 stable for 3 cycles; MemStall high for 3 cycles.
- TIMEOUT_CYCLES=4, DMemReady held 0 -> completion on the 4th ACCESS cycle; RegWriteEN_Out=0, ReadData_Out=32'hDEADBEEF, MemError=1 until RESET.
- Same setup with DMemReady=1 on the 4th ACCESS cycle -> normal load completion, MemError=0.
- RESET asserted on the 2nd ACCESS cycle, then DMemReady=1 -> DMemReq=0 next cycle, all outputs 0, no MEM/WB update.
- Branch_In=1, ZeroFlag_In=1, PC_In=32'h200 -> PCSrc=1, BranchTarget=32'h200 the same cycle.
